// File: rtl/dmem_arbiter.sv
// Round-robin two-port sequencer in front of the single-port data memory.
// Each access runs IDLE -> ACCESS -> RESP with registered grant/done pulses.
module dmem_arbiter #(
  parameter int DEPTH = 64,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [31:0]   addr0,
  input  logic [31:0]   addr1,
  input  logic [DW-1:0] wd0,
  input  logic [DW-1:0] wd1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          done0,
  output logic          done1,
  output logic [DW-1:0] rdata,
  output logic          err,
  output logic          mem_we,
  output logic [31:0]   mem_a,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  localparam logic [29:0] DEPTH_W = 30'(DEPTH);

  state_e state_q;
  logic   owner_q;
  logic   last_q;
  logic   we_q;
  logic   bad_q;

  logic          sel1;
  logic          win_we;
  logic [31:0]   win_addr;
  logic [DW-1:0] win_wd;
  logic          win_bad;

  // Port 1 wins when alone, or on a tie when port 0 was served last.
  assign sel1     = req1 & (~req0 | ~last_q);
  assign win_we   = sel1 ? we1   : we0;
  assign win_addr = sel1 ? addr1 : addr0;
  assign win_wd   = sel1 ? wd1   : wd0;
  assign win_bad  = (win_addr[1:0] != 2'b00) ||
                    (win_addr[31:2] >= DEPTH_W);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      bad_q   <= 1'b0;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      done0   <= 1'b0;
      done1   <= 1'b0;
      err     <= 1'b0;
      rdata   <= '0;
      mem_we  <= 1'b0;
      mem_a   <= '0;
      mem_wd  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req0 || req1) begin
            owner_q <= sel1;
            last_q  <= sel1;
            we_q    <= win_we;
            bad_q   <= win_bad;
            mem_a   <= win_addr;
            mem_wd  <= win_wd;
            mem_we  <= win_we & ~win_bad;
            gnt0    <= ~sel1;
            gnt1    <= sel1;
            state_q <= ACCESS;
          end
        end
        ACCESS: begin
          gnt0    <= 1'b0;
          gnt1    <= 1'b0;
          mem_we  <= 1'b0;
          err     <= bad_q;
          rdata   <= (bad_q | we_q) ? '0 : mem_rd;
          done0   <= ~owner_q;
          done1   <= owner_q;
          state_q <= RESP;
        end
        RESP: begin
          done0   <= 1'b0;
          done1   <= 1'b0;
          err     <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a 64-word behavioural memory.
// Stimulus queues expected grants/responses; a negedge monitor checks them.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic        we0 = 1'b0, we1 = 1'b0;
  logic [31:0] addr0 = '0, addr1 = '0;
  logic [31:0] wd0 = '0, wd1 = '0;
  logic        gnt0, gnt1, done0, done1, err, mem_we;
  logic [31:0] rdata, mem_a, mem_wd, mem_rd;

  dmem_arbiter #(.DEPTH(64), .DW(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .req0   (req0),
    .req1   (req1),
    .we0    (we0),
    .we1    (we1),
    .addr0  (addr0),
    .addr1  (addr1),
    .wd0    (wd0),
    .wd1    (wd1),
    .gnt0   (gnt0),
    .gnt1   (gnt1),
    .done0  (done0),
    .done1  (done1),
    .rdata  (rdata),
    .err    (err),
    .mem_we (mem_we),
    .mem_a  (mem_a),
    .mem_wd (mem_wd),
    .mem_rd (mem_rd)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [64];
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h1111_0000 | 32'(i);
  end
  assign mem_rd = mem[mem_a[7:2]];
  always @(posedge clk) if (mem_we) mem[mem_a[7:2]] <= mem_wd;

  typedef struct {
    int          port;
    logic        mwe;
    logic [31:0] addr;
  } gexp_t;

  typedef struct {
    int          port;
    logic        err;
    logic [31:0] rdata;
  } rexp_t;

  gexp_t gq[$];
  rexp_t rq[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int gcyc = -10;
  int gport = -1;
  bit spacing_on = 0;
  bit prev_ok = 0;

  always @(posedge clk) cyc++;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endfunction

  function automatic void push_g(int p, logic w, logic [31:0] a);
    gexp_t g;
    g.port = p; g.mwe = w; g.addr = a;
    gq.push_back(g);
  endfunction

  function automatic void push_r(int p, logic e, logic [31:0] d);
    rexp_t r;
    r.port = p; r.err = e; r.rdata = d;
    rq.push_back(r);
  endfunction

  always @(negedge clk) begin
    gexp_t g;
    rexp_t r;
    int    gp;
    int    dp;
    tests++;
    if ((gnt0 & gnt1) | (done0 & done1) | (mem_we & ~(gnt0 | gnt1))) begin
      fails++;
      $display("FAIL excl: gnt=%b%b done=%b%b mem_we=%b",
               gnt1, gnt0, done1, done0, mem_we);
    end
    if (gnt0 | gnt1) begin
      gp = gnt1 ? 1 : 0;
      tests++;
      if (gq.size() == 0) begin
        fails++;
        $display("FAIL grant_unexp: port %0d want none", gp);
      end else begin
        g = gq.pop_front();
        if (g.port != gp || g.mwe !== mem_we || g.addr !== mem_a) begin
          fails++;
          $display("FAIL grant: got p%0d we%b a%h want p%0d we%b a%h",
                   gp, mem_we, mem_a, g.port, g.mwe, g.addr);
        end
      end
      if (spacing_on && prev_ok) chk("gnt_spacing", 32'(cyc - gcyc), 32'd3);
      prev_ok = spacing_on;
      gcyc  = cyc;
      gport = gp;
    end
    if (done0 | done1) begin
      dp = done1 ? 1 : 0;
      tests++;
      if (rq.size() == 0) begin
        fails++;
        $display("FAIL done_unexp: port %0d want none", dp);
      end else begin
        r = rq.pop_front();
        if (r.port != dp || r.err !== err || r.rdata !== rdata) begin
          fails++;
          $display("FAIL resp: got p%0d e%b d%h want p%0d e%b d%h",
                   dp, err, rdata, r.port, r.err, r.rdata);
        end
      end
      chk("done_lat", 32'(cyc - gcyc), 32'd1);
      chk("done_port", 32'(dp), 32'(gport));
    end
  end

  task automatic request(input int p, input logic w, input logic [31:0] a,
                         input logic [31:0] d, output int waited);
    bit got;
    got = 0;
    waited = 0;
    if (p == 1) begin
      req1 = 1'b1; we1 = w; addr1 = a; wd1 = d;
    end else begin
      req0 = 1'b1; we0 = w; addr0 = a; wd0 = d;
    end
    for (int i = 0; i < 30 && !got; i++) begin
      @(posedge clk);
      #1;
      waited++;
      got = (p == 1) ? gnt1 : gnt0;
    end
    if (p == 1) req1 = 1'b0;
    else req0 = 1'b0;
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL req_timeout: port %0d got no grant want grant", p);
    end
  endtask

  task automatic drain();
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  logic [31:0] t2_rd0 [4] = '{32'h1111_0010, 32'h1111_0011,
                              32'h1111_0012, 32'h1111_0013};
  logic [31:0] t2_rd1 [4] = '{32'h1111_0020, 32'h1111_0021,
                              32'h1111_0022, 32'h1111_0023};
  logic [31:0] t4_wd  [3] = '{32'hA5A5_0001, 32'hA5A5_0002,
                              32'hA5A5_0003};

  initial begin
    int w;
    #1;
    chk("rst_gnt", {30'd0, gnt1, gnt0}, 32'd0);
    chk("rst_done_err", {29'd0, err, done1, done0}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_a", mem_a, 32'd0);
    chk("rst_mem_wd", mem_wd, 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;

    // write then read, port 0
    push_g(0, 1'b1, 32'h10);
    push_r(0, 1'b0, 32'h0);
    request(0, 1'b1, 32'h10, 32'hDEAD_BEEF, w);
    chk("t1_gnt_lat", 32'(w), 32'd1);
    push_g(0, 1'b0, 32'h10);
    push_r(0, 1'b0, 32'hDEAD_BEEF);
    request(0, 1'b0, 32'h10, 32'h0, w);
    drain();

    // both ports streaming reads; strict alternation from reset
    do_reset();
    for (int k = 0; k < 4; k++) begin
      push_g(0, 1'b0, 32'h40 + 32'(4 * k));
      push_r(0, 1'b0, t2_rd0[k]);
      push_g(1, 1'b0, 32'h80 + 32'(4 * k));
      push_r(1, 1'b0, t2_rd1[k]);
    end
    spacing_on = 1;
    prev_ok = 0;
    fork
      begin
        for (int k = 0; k < 4; k++)
          request(0, 1'b0, 32'h40 + 32'(4 * k), 32'h0, w);
      end
      begin
        int w1;
        for (int k = 0; k < 4; k++)
          request(1, 1'b0, 32'h80 + 32'(4 * k), 32'h0, w1);
      end
    join
    drain();
    spacing_on = 0;

    // blocked accesses
    push_g(1, 1'b0, 32'h102);
    push_r(1, 1'b1, 32'h0);
    request(1, 1'b1, 32'h102, 32'hFFFF_FFFF, w);
    push_g(0, 1'b0, 32'h100);
    push_r(0, 1'b1, 32'h0);
    request(0, 1'b0, 32'h100, 32'h0, w);
    push_g(0, 1'b0, 32'h0);
    push_r(0, 1'b0, 32'h1111_0000);
    request(0, 1'b0, 32'h0, 32'h0, w);
    drain();
    chk("t3_mem0", mem[0], 32'h1111_0000);

    // lone requester back-to-back writes
    spacing_on = 1;
    prev_ok = 0;
    for (int k = 0; k < 3; k++) begin
      push_g(1, 1'b1, 32'(4 * k));
      push_r(1, 1'b0, 32'h0);
      request(1, 1'b1, 32'(4 * k), t4_wd[k], w);
    end
    drain();
    spacing_on = 0;
    for (int k = 0; k < 3; k++) begin
      push_g(0, 1'b0, 32'(4 * k));
      push_r(0, 1'b0, t4_wd[k]);
      request(0, 1'b0, 32'(4 * k), 32'h0, w);
    end
    drain();

    // reset while a write sits in ACCESS
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h20; wd0 = 32'hBAD0_BAD0;
    @(posedge clk);
    #1;
    chk("t5_gnt_seen", {31'd0, gnt0}, 32'd1);
    chk("t5_mwe_seen", {31'd0, mem_we}, 32'd1);
    #1;
    reset = 1'b0;
    req0 = 1'b0;
    #1;
    chk("t5_rst_mwe", {31'd0, mem_we}, 32'd0);
    chk("t5_rst_gnt", {30'd0, gnt1, gnt0}, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    push_g(0, 1'b0, 32'h24);
    push_r(0, 1'b0, 32'h1111_0009);
    push_g(1, 1'b0, 32'h28);
    push_r(1, 1'b0, 32'h1111_000A);
    fork
      request(0, 1'b0, 32'h24, 32'h0, w);
      begin
        int w1;
        request(1, 1'b0, 32'h28, 32'h0, w1);
      end
    join
    drain();
    push_g(0, 1'b0, 32'h20);
    push_r(0, 1'b0, 32'h1111_0008);
    request(0, 1'b0, 32'h20, 32'h0, w);
    drain();

    chk("end_gq_empty", 32'(gq.size()), 32'd0);
    chk("end_rq_empty", 32'(rq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
